// File: rtl/instr_fetch_unit_pkg.sv
// Shared MiniAlu fetch definitions: opcode values, instruction field positions
// and the fetch state encoding.
package instr_fetch_unit_pkg;

  localparam int OPCODE_MSB = 27;
  localparam int OPCODE_LSB = 24;
  localparam int DST_MSB    = 23;
  localparam int DST_LSB    = 16;
  localparam int SRC1_MSB   = 15;
  localparam int SRC1_LSB   = 8;
  localparam int SRC0_MSB   = 7;
  localparam int SRC0_LSB   = 0;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LED   = 4'h1;
  localparam logic [3:0] OP_STO   = 4'h2;
  localparam logic [3:0] OP_IMUL2 = 4'h3;
  localparam logic [3:0] OP_JMP   = 4'h4;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } fetch_state_e;

  function automatic logic [3:0] insn_opcode(input logic [27:0] insn);
    return insn[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_pipe_reg.sv
// Valid/ready holding register between fetch and execute; flush drops the
// held entry, load captures a new one.
module fetch_pipe_reg #(
  parameter int WIDTH = 44
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // Flush wins over load so a redirect can never be overwritten by a capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/instr_fetch_unit.sv
// MiniAlu fetch stage: owns the PC, resolves JMP locally, applies execute
// redirects and feeds a valid/ready register to execute.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int INSN_W = 28
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic [ADDR_W-1:0] oAddress,
  input  logic [INSN_W-1:0] iInstruction,
  output logic [INSN_W-1:0] oInstruction,
  output logic [ADDR_W-1:0] oPC,
  output logic              oValid,
  input  logic              iReady,
  input  logic              iBranchTaken,
  input  logic [ADDR_W-1:0] iBranchTarget,
  output logic [15:0]       oFetchCount
);

  localparam int PIPE_W = INSN_W + ADDR_W;

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [15:0]       r_fetch_count;
  logic              w_valid;
  logic              w_adv;
  logic              w_is_jmp;
  logic              w_load;
  logic              w_flush;
  logic [ADDR_W-1:0] w_jmp_target;
  logic [PIPE_W-1:0] w_pipe_in;
  logic [PIPE_W-1:0] w_pipe_out;

  assign w_adv        = !w_valid || iReady;
  assign w_is_jmp     = (iInstruction[OPCODE_MSB:OPCODE_LSB] == OP_JMP);
  assign w_jmp_target = {{(ADDR_W-8){1'b0}}, iInstruction[DST_MSB:DST_LSB]};
  assign w_pipe_in    = {iInstruction, r_pc};

  // A stall is left through the same advance path as S_RUN, so the cycle
  // that accepts the held word also captures its successor.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_load       = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      S_START: begin
        w_state_next = S_RUN;
      end
      S_RUN, S_STALL: begin
        if (iBranchTaken) begin
          w_pc_next    = iBranchTarget;
          w_flush      = 1'b1;
          w_state_next = S_RUN;
        end else if (w_adv) begin
          w_state_next = S_RUN;
          if (w_is_jmp) begin
            w_flush   = 1'b1;
            w_pc_next = w_jmp_target;
          end else begin
            w_load    = 1'b1;
            w_pc_next = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end else begin
          w_state_next = S_STALL;
        end
      end
      default: begin
        w_state_next = S_START;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_START;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_pc <= '0;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // Counts accepted transfers, including one that coincides with a redirect.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_fetch_count <= 16'd0;
    end else if (w_valid && iReady) begin
      r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  fetch_pipe_reg #(
    .WIDTH (PIPE_W)
  ) u_pipe (
    .i_clk   (Clock),
    .i_rst_n (Reset),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_data  (w_pipe_in),
    .o_data  (w_pipe_out),
    .o_valid (w_valid)
  );

  assign oAddress     = r_pc;
  assign oInstruction = w_pipe_out[PIPE_W-1:ADDR_W];
  assign oPC          = w_pipe_out[ADDR_W-1:0];
  assign oValid       = w_valid;
  assign oFetchCount  = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scenario bench for instr_fetch_unit with a behavioural ROM and a scoreboard
// of expected accepted transfers.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic [27:0] oInstruction;
  logic [15:0] oPC;
  logic        oValid;
  logic        iReady;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;
  logic [15:0] oFetchCount;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] pc;
    logic [27:0] insn;
  } exp_t;
  exp_t sb[$];

  instr_fetch_unit #(.ADDR_W(16), .INSN_W(28)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .oAddress      (oAddress),
    .iInstruction  (iInstruction),
    .oInstruction  (oInstruction),
    .oPC           (oPC),
    .oValid        (oValid),
    .iReady        (iReady),
    .iBranchTaken  (iBranchTaken),
    .iBranchTarget (iBranchTarget),
    .oFetchCount   (oFetchCount)
  );

  always #5 Clock = ~Clock;

  // Program: 0 NOP, 1 STO, 2 STO, 3 NOP, 4 IMUL2, 5 JMP 1; elsewhere LED.
  function automatic logic [27:0] rom_word(input logic [15:0] a);
    case (a)
      16'd0:   return {OP_NOP,   8'h10, 8'h20, 8'h00};
      16'd1:   return {OP_STO,   8'h11, 8'h21, 8'h01};
      16'd2:   return {OP_STO,   8'h12, 8'h22, 8'h02};
      16'd3:   return {OP_NOP,   8'h13, 8'h23, 8'h03};
      16'd4:   return {OP_IMUL2, 8'h14, 8'h24, 8'h04};
      16'd5:   return {OP_JMP,   8'h01, 8'h00, 8'h05};
      default: return {OP_LED,   a[7:0], a[15:8], 8'h5A};
    endcase
  endfunction

  always_comb iInstruction = rom_word(oAddress);

  // Scoreboard: every accepted transfer must match the next expected entry.
  always @(negedge Clock) begin
    if (Reset === 1'b1 && oValid === 1'b1 && iReady === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got pc=%h insn=%h required none", oPC, oInstruction);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (oPC !== e.pc || oInstruction !== e.insn) begin
          failures++;
          $display("FAIL sb_transfer got pc=%h insn=%h required pc=%h insn=%h",
                   oPC, oInstruction, e.pc, e.insn);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] pc);
    exp_t e;
    e.pc   = pc;
    e.insn = rom_word(pc);
    sb.push_back(e);
  endtask

  task automatic reset_dut();
    Reset         = 1'b0;
    iReady        = 1'b0;
    iBranchTaken  = 1'b0;
    iBranchTarget = 16'h0000;
    sb.delete();
    repeat (2) tick();
    Reset = 1'b1;
  endtask

  task automatic wait_pc(input logic [15:0] target);
    bit found = 0;
    for (int i = 0; i < 50; i++) begin
      if (oValid === 1'b1 && oPC === target) begin
        found = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wait_pc timeout got pc=%h valid=%b required pc=%h", oPC, oValid, target);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; iReady = 1'b0; iBranchTaken = 1'b0; iBranchTarget = 16'h0;
    tick();
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL rst_valid got %b required 0", oValid); end
    checks++; if (oPC !== 16'h0) begin failures++; $display("FAIL rst_pc got %h required 0000", oPC); end
    checks++; if (oAddress !== 16'h0) begin failures++; $display("FAIL rst_addr got %h required 0000", oAddress); end
    checks++; if (oInstruction !== 28'h0) begin failures++; $display("FAIL rst_insn got %h required 0", oInstruction); end
    checks++; if (oFetchCount !== 16'h0) begin failures++; $display("FAIL rst_count got %h required 0", oFetchCount); end
    Reset = 1'b1;
    tick();
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL start_novalid got %b required 0", oValid); end
    tick();
    checks++; if (oValid !== 1'b1 || oPC !== 16'h0) begin failures++; $display("FAIL first_valid got v=%b pc=%h required v=1 pc=0000", oValid, oPC); end
    checks++; if (oInstruction !== rom_word(16'h0)) begin failures++; $display("FAIL first_insn got %h required %h", oInstruction, rom_word(16'h0)); end
    checks++; if (oAddress !== 16'h1) begin failures++; $display("FAIL first_addr got %h required 0001", oAddress); end
    $display("test_reset done");
  endtask

  task automatic test_program();
    reset_dut();
    iReady = 1'b1;
    for (int k = 0; k < 5; k++) push_exp(16'(k));
    push_exp(16'h1);
    wait_pc(16'h0);
    for (int k = 1; k < 5; k++) begin
      tick();
      checks++;
      if (oValid !== 1'b1 || oPC !== 16'(k)) begin
        failures++; $display("FAIL prog_seq got v=%b pc=%h required v=1 pc=%h", oValid, oPC, 16'(k));
      end
    end
    tick();
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL jmp_bubble got %b required 0", oValid); end
    checks++; if (oAddress !== 16'h1) begin failures++; $display("FAIL jmp_addr got %h required 0001", oAddress); end
    checks++; if (oFetchCount !== 16'd5) begin failures++; $display("FAIL jmp_count got %0d required 5", oFetchCount); end
    tick();
    checks++; if (oValid !== 1'b1 || oPC !== 16'h1) begin failures++; $display("FAIL jmp_target got v=%b pc=%h required v=1 pc=0001", oValid, oPC); end
    tick();
    iReady = 1'b0;
    checks++; if (oValid !== 1'b1 || oPC !== 16'h2) begin failures++; $display("FAIL jmp_next got v=%b pc=%h required v=1 pc=0002", oValid, oPC); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL prog_sb_left got %0d required 0", sb.size()); end
    $display("test_program done");
  endtask

  task automatic test_stall();
    reset_dut();
    iReady = 1'b1;
    push_exp(16'h0); push_exp(16'h1);
    wait_pc(16'h2);
    iReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (oValid !== 1'b1 || oPC !== 16'h2 || oInstruction !== rom_word(16'h2) || oAddress !== 16'h3) begin
        failures++;
        $display("FAIL stall_hold got v=%b pc=%h insn=%h addr=%h required v=1 pc=0002 insn=%h addr=0003",
                 oValid, oPC, oInstruction, oAddress, rom_word(16'h2));
      end
    end
    checks++; if (oFetchCount !== 16'd2) begin failures++; $display("FAIL stall_count got %0d required 2", oFetchCount); end
    push_exp(16'h2);
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    checks++; if (oValid !== 1'b1 || oPC !== 16'h3) begin failures++; $display("FAIL stall_release got v=%b pc=%h required v=1 pc=0003", oValid, oPC); end
    checks++; if (oFetchCount !== 16'd3) begin failures++; $display("FAIL release_count got %0d required 3", oFetchCount); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL stall_sb_left got %0d required 0", sb.size()); end
    $display("test_stall done");
  endtask

  task automatic test_branch_stall();
    reset_dut();
    iReady = 1'b1;
    push_exp(16'h0); push_exp(16'h1);
    wait_pc(16'h2);
    iReady = 1'b0;
    tick();
    iBranchTaken = 1'b1; iBranchTarget = 16'h0004;
    tick();
    iBranchTaken = 1'b0;
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL br_flush got %b required 0", oValid); end
    checks++; if (oAddress !== 16'h4) begin failures++; $display("FAIL br_addr got %h required 0004", oAddress); end
    checks++; if (oFetchCount !== 16'd2) begin failures++; $display("FAIL br_count got %0d required 2", oFetchCount); end
    iReady = 1'b1;
    push_exp(16'h4);
    tick();
    checks++; if (oValid !== 1'b1 || oPC !== 16'h4) begin failures++; $display("FAIL br_target got v=%b pc=%h required v=1 pc=0004", oValid, oPC); end
    tick();
    checks++; if (oValid !== 1'b0 || oAddress !== 16'h1) begin failures++; $display("FAIL br_then_jmp got v=%b addr=%h required v=0 addr=0001", oValid, oAddress); end
    checks++; if (oFetchCount !== 16'd3) begin failures++; $display("FAIL br_count2 got %0d required 3", oFetchCount); end
    iReady = 1'b0;
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL br_sb_left got %0d required 0", sb.size()); end
    $display("test_branch_stall done");
  endtask

  task automatic test_branch_jmp();
    reset_dut();
    iReady = 1'b1;
    for (int k = 0; k < 5; k++) push_exp(16'(k));
    wait_pc(16'h4);
    iBranchTaken = 1'b1; iBranchTarget = 16'h0003;
    tick();
    iBranchTaken = 1'b0;
    checks++; if (oValid !== 1'b0 || oAddress !== 16'h3) begin failures++; $display("FAIL brjmp_pc got v=%b addr=%h required v=0 addr=0003", oValid, oAddress); end
    checks++; if (oFetchCount !== 16'd5) begin failures++; $display("FAIL brjmp_count got %0d required 5", oFetchCount); end
    tick();
    iReady = 1'b0;
    checks++; if (oValid !== 1'b1 || oPC !== 16'h3 || oInstruction !== rom_word(16'h3)) begin
      failures++; $display("FAIL brjmp_target got v=%b pc=%h insn=%h required v=1 pc=0003 insn=%h", oValid, oPC, oInstruction, rom_word(16'h3));
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL brjmp_sb_left got %0d required 0", sb.size()); end
    $display("test_branch_jmp done");
  endtask

  task automatic test_wrap();
    reset_dut();
    iReady = 1'b1;
    tick();
    iBranchTaken = 1'b1; iBranchTarget = 16'hFFFF;
    tick();
    iBranchTaken = 1'b0;
    checks++; if (oAddress !== 16'hFFFF || oValid !== 1'b0) begin failures++; $display("FAIL wrap_branch got addr=%h v=%b required addr=ffff v=0", oAddress, oValid); end
    push_exp(16'hFFFF);
    tick();
    checks++; if (oAddress !== 16'h0000) begin failures++; $display("FAIL wrap_addr got %h required 0000", oAddress); end
    checks++; if (oValid !== 1'b1 || oPC !== 16'hFFFF || oInstruction !== rom_word(16'hFFFF)) begin
      failures++; $display("FAIL wrap_out got v=%b pc=%h insn=%h required v=1 pc=ffff insn=%h", oValid, oPC, oInstruction, rom_word(16'hFFFF));
    end
    tick();
    iReady = 1'b0;
    checks++; if (oPC !== 16'h0000 || oFetchCount !== 16'd1) begin failures++; $display("FAIL wrap_next got pc=%h cnt=%0d required pc=0000 cnt=1", oPC, oFetchCount); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL wrap_sb_left got %0d required 0", sb.size()); end
    $display("test_wrap done");
  endtask

  task automatic test_async_reset();
    reset_dut();
    iReady = 1'b1;
    push_exp(16'h0); push_exp(16'h1);
    wait_pc(16'h2);
    iReady = 1'b0;
    tick();
    #2;
    Reset = 1'b0;
    #1;
    checks++; if (oValid !== 1'b0 || oPC !== 16'h0 || oAddress !== 16'h0 || oFetchCount !== 16'h0) begin
      failures++; $display("FAIL async_rst got v=%b pc=%h addr=%h cnt=%h required all 0", oValid, oPC, oAddress, oFetchCount);
    end
    tick();
    Reset = 1'b1;
    iReady = 1'b1;
    tick();
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL async_start got %b required 0", oValid); end
    tick();
    iReady = 1'b0;
    checks++; if (oValid !== 1'b1 || oPC !== 16'h0) begin failures++; $display("FAIL async_first got v=%b pc=%h required v=1 pc=0000", oValid, oPC); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL async_sb_left got %0d required 0", sb.size()); end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_program();
    test_stall();
    test_branch_stall();
    test_branch_jmp();
    test_wrap();
    test_async_reset();
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
